// File: rtl/sc_regshifter_flags_if.sv
// Register/shifter bus: ALU result and flags in, registered data and active-low status flags out.
// The master modport is the ALU/state-machine side; the slave modport is the shifter.
interface sc_regshifter_flags_if #(
  parameter int DATAWIDTH_BUS                  = 8,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
);
  logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_Data_InBUS;
  logic                                      SC_REGSHIFTER_Load_InLow;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_REGSHIFTER_ShiftSelection_InLow;
  logic                                      SC_REGSHIFTER_ALUCarry_InHigh;
  logic                                      SC_REGSHIFTER_ALUOverflow_InHigh;
  logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_Data_OutBUS;
  logic                                      SC_REGSHIFTER_Overflow_OutLow;
  logic                                      SC_REGSHIFTER_Carry_OutLow;
  logic                                      SC_REGSHIFTER_Negative_OutLow;
  logic                                      SC_REGSHIFTER_Zero_OutLow;

  modport master (
    output SC_REGSHIFTER_Data_InBUS,
    output SC_REGSHIFTER_Load_InLow,
    output SC_REGSHIFTER_ShiftSelection_InLow,
    output SC_REGSHIFTER_ALUCarry_InHigh,
    output SC_REGSHIFTER_ALUOverflow_InHigh,
    input  SC_REGSHIFTER_Data_OutBUS,
    input  SC_REGSHIFTER_Overflow_OutLow,
    input  SC_REGSHIFTER_Carry_OutLow,
    input  SC_REGSHIFTER_Negative_OutLow,
    input  SC_REGSHIFTER_Zero_OutLow
  );

  modport slave (
    input  SC_REGSHIFTER_Data_InBUS,
    input  SC_REGSHIFTER_Load_InLow,
    input  SC_REGSHIFTER_ShiftSelection_InLow,
    input  SC_REGSHIFTER_ALUCarry_InHigh,
    input  SC_REGSHIFTER_ALUOverflow_InHigh,
    output SC_REGSHIFTER_Data_OutBUS,
    output SC_REGSHIFTER_Overflow_OutLow,
    output SC_REGSHIFTER_Carry_OutLow,
    output SC_REGSHIFTER_Negative_OutLow,
    output SC_REGSHIFTER_Zero_OutLow
  );
endinterface

// File: rtl/sc_regshifter_flags.sv
// Result register with load / logical shift left / shift right and active-low N/Z/C/V flags.
// Latency: one clock, every output straight from a flop. Backpressure: none, an operation is accepted every cycle.
module sc_regshifter_flags #(
  parameter int DATAWIDTH_BUS                  = 8,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
  input  logic                 SC_REGSHIFTER_CLOCK_50,
  input  logic                 SC_REGSHIFTER_Reset_InHigh,
  sc_regshifter_flags_if.slave regshifter_bus
);

  localparam int W  = DATAWIDTH_BUS;
  localparam int SW = DATAWIDTH_REGSHIFTER_SELECTION;

  localparam logic [SW-1:0] SEL_LEFT  = SW'(1);
  localparam logic [SW-1:0] SEL_RIGHT = SW'(2);

  // Flags are kept in their active-low output form so the ports are driven by flops directly.
  typedef struct packed {
    logic overflow_n;
    logic carry_n;
    logic negative_n;
    logic zero_n;
  } flags_n_t;

  localparam flags_n_t FLAGS_RESET = '{overflow_n: 1'b1, carry_n: 1'b1, negative_n: 1'b1, zero_n: 1'b0};

  logic [W-1:0] data_q;
  logic [W-1:0] data_nxt;
  flags_n_t     flags_q;
  flags_n_t     flags_nxt;
  logic         result_update;

  always_comb begin
    data_nxt      = data_q;
    flags_nxt     = flags_q;
    result_update = 1'b0;
    if (!regshifter_bus.SC_REGSHIFTER_Load_InLow) begin
      data_nxt             = regshifter_bus.SC_REGSHIFTER_Data_InBUS;
      flags_nxt.carry_n    = ~regshifter_bus.SC_REGSHIFTER_ALUCarry_InHigh;
      flags_nxt.overflow_n = ~regshifter_bus.SC_REGSHIFTER_ALUOverflow_InHigh;
      result_update        = 1'b1;
    end else if (regshifter_bus.SC_REGSHIFTER_ShiftSelection_InLow == SEL_LEFT) begin
      // Left shift flags a sign change as signed overflow.
      data_nxt             = {data_q[W-2:0], 1'b0};
      flags_nxt.carry_n    = ~data_q[W-1];
      flags_nxt.overflow_n = ~(data_q[W-1] ^ data_q[W-2]);
      result_update        = 1'b1;
    end else if (regshifter_bus.SC_REGSHIFTER_ShiftSelection_InLow == SEL_RIGHT) begin
      data_nxt             = {1'b0, data_q[W-1:1]};
      flags_nxt.carry_n    = ~data_q[0];
      flags_nxt.overflow_n = 1'b1;
      result_update        = 1'b1;
    end
    if (result_update) begin
      flags_nxt.negative_n = ~data_nxt[W-1];
      flags_nxt.zero_n     = (data_nxt != '0);
    end
  end

  always_ff @(posedge SC_REGSHIFTER_CLOCK_50 or posedge SC_REGSHIFTER_Reset_InHigh) begin
    if (SC_REGSHIFTER_Reset_InHigh) begin
      data_q  <= '0;
      flags_q <= FLAGS_RESET;
    end else begin
      data_q  <= data_nxt;
      flags_q <= flags_nxt;
    end
  end

  assign regshifter_bus.SC_REGSHIFTER_Data_OutBUS     = data_q;
  assign regshifter_bus.SC_REGSHIFTER_Overflow_OutLow = flags_q.overflow_n;
  assign regshifter_bus.SC_REGSHIFTER_Carry_OutLow    = flags_q.carry_n;
  assign regshifter_bus.SC_REGSHIFTER_Negative_OutLow = flags_q.negative_n;
  assign regshifter_bus.SC_REGSHIFTER_Zero_OutLow     = flags_q.zero_n;

endmodule

// File: tb/tb_sc_regshifter_flags.sv
// Directed bench for sc_regshifter_flags at W=8; flag nibbles are {Overflow, Carry, Negative, Zero}_OutLow.
module tb_sc_regshifter_flags;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  sc_regshifter_flags_if #(.DATAWIDTH_BUS(8), .DATAWIDTH_REGSHIFTER_SELECTION(2)) bus ();

  sc_regshifter_flags #(.DATAWIDTH_BUS(8), .DATAWIDTH_REGSHIFTER_SELECTION(2)) dut (
    .SC_REGSHIFTER_CLOCK_50     (clk),
    .SC_REGSHIFTER_Reset_InHigh (rst),
    .regshifter_bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic load_n, input logic [7:0] din, input logic [1:0] sel,
                       input logic alu_c, input logic alu_v);
    bus.SC_REGSHIFTER_Load_InLow           = load_n;
    bus.SC_REGSHIFTER_Data_InBUS           = din;
    bus.SC_REGSHIFTER_ShiftSelection_InLow = sel;
    bus.SC_REGSHIFTER_ALUCarry_InHigh      = alu_c;
    bus.SC_REGSHIFTER_ALUOverflow_InHigh   = alu_v;
  endtask

  task automatic check(input string tag, input logic [7:0] exp_d, input logic [3:0] exp_f);
    logic [11:0] obs;
    logic [11:0] exp_v;
    obs   = {bus.SC_REGSHIFTER_Data_OutBUS, bus.SC_REGSHIFTER_Overflow_OutLow,
             bus.SC_REGSHIFTER_Carry_OutLow, bus.SC_REGSHIFTER_Negative_OutLow,
             bus.SC_REGSHIFTER_Zero_OutLow};
    exp_v = {exp_d, exp_f};
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed data=%h flags=%b, expected data=%h flags=%b",
             tag, obs[11:4], obs[3:0], exp_v[11:4], exp_v[3:0]);
    end
  endtask

  // Apply one operation, clock it, and compare one time unit after the edge.
  task automatic step(input string tag, input logic load_n, input logic [7:0] din, input logic [1:0] sel,
                      input logic alu_c, input logic alu_v, input logic [7:0] exp_d, input logic [3:0] exp_f);
    drive(load_n, din, sel, alu_c, alu_v);
    @(posedge clk);
    #1;
    check(tag, exp_d, exp_f);
  endtask

  initial begin
    logic [7:0] old_v;
    logic [7:0] new_v;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    drive(1'b1, 8'h00, 2'b00, 1'b0, 1'b0);
    #3;
    check("reset_state", 8'h00, 4'b1110);
    @(negedge clk);
    rst = 1'b0;

    step("load_5a", 1'b0, 8'h5A, 2'b00, 1'b0, 1'b0, 8'h5A, 4'b1111);

    // Asynchronous reset between edges, with a load held pending through reset.
    drive(1'b0, 8'h77, 2'b00, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 8'h00, 4'b1110);
    @(posedge clk);
    #1;
    check("load_ignored_in_reset", 8'h00, 4'b1110);
    #2;
    rst = 1'b0;
    step("first_edge_after_reset", 1'b0, 8'h77, 2'b00, 1'b0, 1'b0, 8'h77, 4'b1111);

    step("load_80_cv", 1'b0, 8'h80, 2'b00, 1'b1, 1'b1, 8'h80, 4'b0001);
    step("load_zero", 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 4'b1010);

    step("load_40", 1'b0, 8'h40, 2'b00, 1'b0, 1'b0, 8'h40, 4'b1111);
    step("shl_40", 1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 8'h80, 4'b0101);

    step("load_01", 1'b0, 8'h01, 2'b00, 1'b0, 1'b0, 8'h01, 4'b1111);
    step("shr_01", 1'b1, 8'h00, 2'b10, 1'b0, 1'b0, 8'h00, 4'b1010);
    step("hold_00", 1'b1, 8'hC3, 2'b00, 1'b1, 1'b1, 8'h00, 4'b1010);

    step("load_over_shift", 1'b0, 8'h33, 2'b01, 1'b0, 1'b0, 8'h33, 4'b1111);
    for (int i = 0; i < 3; i++)
      step("hold_11", 1'b1, 8'hAA, 2'b11, 1'b1, 1'b1, 8'h33, 4'b1111);

    // Inputs changing mid-cycle must not reach the outputs.
    drive(1'b0, 8'hAA, 2'b10, 1'b1, 1'b1);
    #3;
    check("no_comb_path", 8'h33, 4'b1111);

    step("load_ff", 1'b0, 8'hFF, 2'b00, 1'b0, 1'b0, 8'hFF, 4'b1101);
    for (int k = 1; k <= 8; k++) begin
      new_v = 8'hFF >> k;
      step("shr_ff_seq", 1'b1, 8'h00, 2'b10, 1'b0, 1'b0, new_v, {3'b101, (k != 8)});
    end

    step("reload_ff", 1'b0, 8'hFF, 2'b00, 1'b1, 1'b0, 8'hFF, 4'b1001);
    for (int k = 1; k <= 8; k++) begin
      old_v = 8'hFF << (k - 1);
      new_v = 8'hFF << k;
      step("shl_ff_seq", 1'b1, 8'h00, 2'b01, 1'b0, 1'b0, new_v,
           {~(old_v[7] ^ old_v[6]), ~old_v[7], ~new_v[7], (new_v != 8'h00)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
